// File: rtl/score_tracker_module.sv
// score_tracker_module: Simon round counter and game-state tracker feeding the 7-segment controller.
// Optional best-score record is enabled by defining HIGH_SCORE_EN.
`default_nettype none

module score_tracker_module #(
  parameter int MAX_SCORE   = 32,
  parameter int BLINK_TICKS = 50_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_round_ok,
  input  logic       i_fail,
  input  logic       i_show_best,
  output logic [5:0] o_number,
  output logic       o_blank,
  output logic [1:0] o_state,
  output logic [5:0] o_best
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_PLAY = 2'b01;
  localparam logic [1:0] ST_WIN  = 2'b10;
  localparam logic [1:0] ST_OVER = 2'b11;

  localparam logic [5:0] MAX_SCORE_V = 6'(MAX_SCORE);
  localparam int         BLINK_W     = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

  logic [1:0]         state, state_nxt;
  logic [5:0]         score, score_nxt;
  logic [5:0]         score_inc;
  logic [BLINK_W-1:0] blink_cnt, blink_cnt_nxt;
  logic               blink, blink_nxt;
  logic [5:0]         number_nxt;
  logic               blank_nxt;
  logic               ended, ended_nxt;

  assign score_inc = score + 6'd1;
  assign ended     = (state == ST_WIN) || (state == ST_OVER);
  assign ended_nxt = (state_nxt == ST_WIN) || (state_nxt == ST_OVER);

  // start outranks everything; fail outranks round_ok while playing
  always_comb begin
    state_nxt = state;
    score_nxt = score;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          state_nxt = ST_PLAY;
          score_nxt = 6'd0;
        end
      end
      ST_PLAY: begin
        if (i_start) begin
          score_nxt = 6'd0;
        end else if (i_fail) begin
          state_nxt = ST_OVER;
        end else if (i_round_ok) begin
          score_nxt = score_inc;
          if (score_inc == MAX_SCORE_V) begin
            state_nxt = ST_WIN;
          end
        end
      end
      default: begin
        if (i_start) begin
          state_nxt = ST_PLAY;
          score_nxt = 6'd0;
        end
      end
    endcase
  end

  // Blink only advances while staying in an end-of-game state, so entry always starts unblanked.
  always_comb begin
    blink_cnt_nxt = '0;
    blink_nxt     = 1'b0;
    if (ended && ended_nxt) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_nxt = '0;
        blink_nxt     = ~blink;
      end else begin
        blink_cnt_nxt = blink_cnt + 1'b1;
        blink_nxt     = blink;
      end
    end
  end

`ifdef HIGH_SCORE_EN
  logic [5:0] best, best_nxt;
  logic       show_best;

  always_comb begin
    best_nxt = best;
    if ((state == ST_PLAY) && ended_nxt && (score_nxt > best)) begin
      best_nxt = score_nxt;
    end
  end

  assign show_best  = i_show_best && (state_nxt != ST_PLAY);
  assign number_nxt = show_best ? best_nxt : score_nxt;
  assign blank_nxt  = show_best ? 1'b0 : blink_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      best <= 6'd0;
    end else begin
      best <= best_nxt;
    end
  end

  assign o_best = best;
`else
  logic unused_show_best;

  assign unused_show_best = i_show_best;
  assign number_nxt       = score_nxt;
  assign blank_nxt        = blink_nxt;
  assign o_best           = 6'd0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      score     <= 6'd0;
      blink_cnt <= '0;
      blink     <= 1'b0;
      o_number  <= 6'd0;
      o_blank   <= 1'b0;
    end else begin
      state     <= state_nxt;
      score     <= score_nxt;
      blink_cnt <= blink_cnt_nxt;
      blink     <= blink_nxt;
      o_number  <= number_nxt;
      o_blank   <= blank_nxt;
    end
  end

  assign o_state = state;

endmodule

`default_nettype wire

// File: tb/tb_score_tracker_module.sv
// Directed vector bench for score_tracker_module with MAX_SCORE=32, BLINK_TICKS=4.
`default_nettype none

module tb_score_tracker_module;

  logic       clk;
  logic       rst_n;
  logic       start, round_ok, fail, show_best;
  logic [5:0] number;
  logic       blank;
  logic [1:0] state;
  logic [5:0] best;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] PLAY = 2'b01;
  localparam logic [1:0] WIN  = 2'b10;
  localparam logic [1:0] OVER = 2'b11;

  typedef struct {
    logic       s, ok, f, sh;
    logic [5:0] num;
    logic       blk;
    logic [1:0] st;
    logic [5:0] bst;
  } vec_t;

  vec_t vecs[$];

  score_tracker_module #(.MAX_SCORE(32), .BLINK_TICKS(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_round_ok  (round_ok),
    .i_fail      (fail),
    .i_show_best (show_best),
    .o_number    (number),
    .o_blank     (blank),
    .o_state     (state),
    .o_best      (best)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // picks the expectation for the build: first value with best-score support, second without
  function automatic int hs(input int with_best, input int without_best);
`ifdef HIGH_SCORE_EN
    return with_best;
`else
    return without_best;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int n, input int bl, input int st, input int bs);
    check({tag, " number"}, number, n);
    check({tag, " blank"}, blank, bl);
    check({tag, " state"}, state, st);
    check({tag, " best"}, best, bs);
  endtask

  task automatic step(input logic s, input logic ok, input logic f, input logic sh);
    @(negedge clk);
    start = s; round_ok = ok; fail = f; show_best = sh;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic s, input logic ok, input logic f, input logic sh,
                     input int num, input int blk, input logic [1:0] st, input int bst);
    vec_t v;
    v.s = s; v.ok = ok; v.f = f; v.sh = sh;
    v.num = 6'(num); v.blk = blk[0]; v.st = st; v.bst = 6'(bst);
    vecs.push_back(v);
  endtask

  initial begin
    start = 0; round_ok = 0; fail = 0; show_best = 0;
    rst_n = 1'b0;

    // start, five rounds, then to 7 and a simultaneous ok+fail
    add(1,0,0,0, 0,0,PLAY,0);
    for (int i = 1; i <= 5; i++) add(0,1,0,0, i,0,PLAY,0);
    add(0,0,0,0, 5,0,PLAY,0);
    add(0,1,0,0, 6,0,PLAY,0);
    add(0,1,0,0, 7,0,PLAY,0);
    add(0,1,1,0, 7,0,OVER,hs(7,0));
    // OVER: inputs ignored, blank toggles every 4 cycles after entry
    add(0,1,0,0, 7,0,OVER,hs(7,0));
    add(0,0,1,0, 7,0,OVER,hs(7,0));
    add(0,0,0,0, 7,0,OVER,hs(7,0));
    add(0,0,0,0, 7,1,OVER,hs(7,0));
    add(0,1,0,0, 7,1,OVER,hs(7,0));
    add(0,0,0,0, 7,1,OVER,hs(7,0));
    add(0,0,0,0, 7,1,OVER,hs(7,0));
    add(0,0,0,0, 7,0,OVER,hs(7,0));
    // restart beats round_ok; show_best ignored while playing; start beats fail
    add(1,1,0,0, 0,0,PLAY,hs(7,0));
    add(0,0,0,1, 0,0,PLAY,hs(7,0));
    add(0,1,0,1, 1,0,PLAY,hs(7,0));
    add(1,0,1,0, 0,0,PLAY,hs(7,0));
    for (int i = 1; i <= 9; i++) add(0,1,0,0, i,0,PLAY,hs(7,0));
    add(0,0,1,0, 9,0,OVER,hs(9,0));
    // second game ends at 4; best stays 9 and can be shown in OVER
    add(1,0,0,0, 0,0,PLAY,hs(9,0));
    for (int i = 1; i <= 4; i++) add(0,1,0,0, i,0,PLAY,hs(9,0));
    add(0,0,1,0, 4,0,OVER,hs(9,0));
    add(0,0,0,1, hs(9,4),0,OVER,hs(9,0));
    add(0,0,0,1, hs(9,4),0,OVER,hs(9,0));
    add(0,0,0,1, hs(9,4),0,OVER,hs(9,0));
    add(0,0,0,1, hs(9,4),hs(0,1),OVER,hs(9,0));
    add(0,0,0,0, 4,1,OVER,hs(9,0));
    add(1,0,0,0, 0,0,PLAY,hs(9,0));

    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, IDLE, 0);
    step(0,1,1,0);
    check_all("idle ignores pulses", 0, 0, IDLE, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0,1,0,0);
    check_all("idle ignores ok", 0, 0, IDLE, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].s, vecs[i].ok, vecs[i].f, vecs[i].sh);
      check_all($sformatf("vec%0d", i), vecs[i].num, vecs[i].blk, vecs[i].st, vecs[i].bst);
    end

    // climb to the maximum score and win
    for (int i = 1; i <= 31; i++) begin
      step(0,1,0,0);
      check($sformatf("climb%0d number", i), number, i);
    end
    check("climb state", state, PLAY);
    step(0,1,0,0);
    check_all("win entry", 32, 0, WIN, hs(32,0));
    for (int k = 1; k <= 8; k++) begin
      step(0,1,1,0);
      check_all($sformatf("win blink%0d", k), 32, (k >= 4 && k < 8) ? 1 : 0, WIN, hs(32,0));
    end

    // asynchronous reset in mid-game at score 12
    step(1,0,0,0);
    for (int i = 1; i <= 12; i++) step(0,1,0,0);
    check("pre-reset number", number, 12);
    @(negedge clk);
    start = 0; round_ok = 0; fail = 0; show_best = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async reset", 0, 0, IDLE, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1,0,0,0);
    check_all("post-reset start", 0, 0, PLAY, 0);
    step(0,1,0,0);
    check_all("post-reset round", 1, 0, PLAY, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
